// File: rtl/ahfp_cordic_range_reduce.sv
// Purpose: reduces a float32 rotation angle into [-pi/2, pi/2] by repeatedly stepping pi and negating x/y.
// Latency: 2 cycles for an in-range angle, plus ADD_LAT+1 cycles per reduction step.
// Backpressure: one triple in flight; in_ready only in IDLE, result held while out_ready is low.

module ahfp_add_sub #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dataa_i,
    input  logic [31:0] datab_i,
    output logic [31:0] result_o
);
    logic [31:0] pipe_q [LAT];

    // Normal-range float32 add with round-to-nearest-even; tiny results flush to signed zero.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] big, sml;
        logic [26:0] mb, ms;
        logic [27:0] s;
        logic [24:0] m;
        logic        sticky;
        int          eb, es, d, e, lead;
        if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        eb = (big[30:23] == 8'd0) ? 1 : int'(big[30:23]);
        es = (sml[30:23] == 8'd0) ? 1 : int'(sml[30:23]);
        mb = {big[30:23] != 8'd0, big[22:0], 3'b000};
        ms = {sml[30:23] != 8'd0, sml[22:0], 3'b000};
        d  = eb - es;
        sticky = 1'b0;
        for (int i = 0; i < 27; i++) begin
            if (i < d) sticky = sticky | ms[i];
        end
        ms    = (d > 26) ? 27'd0 : (ms >> d);
        ms[0] = ms[0] | sticky;
        if (big[31] == sml[31]) s = {1'b0, mb} + {1'b0, ms};
        else                    s = {1'b0, mb} - {1'b0, ms};
        e = eb;
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 1;
        end
        lead = -1;
        for (int i = 0; i < 27; i++) begin
            if (s[i]) lead = i;
        end
        if (lead < 0) return 32'd0;
        if ((26 - lead) >= e) return {big[31], 31'd0};
        s = s << (26 - lead);
        e = e - (26 - lead);
        m = {1'b0, s[26:3]} + {24'd0, s[2] & (s[1] | s[0] | s[3])};
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 255) return {big[31], 8'hFF, 23'd0};
        return {big[31], e[7:0], m[22:0]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pipe_q[i] <= 32'd0;
        end else begin
            pipe_q[0] <= fp_add(dataa_i, datab_i);
            for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign result_o = pipe_q[LAT-1];
endmodule

module ahfp_cordic_range_reduce #(
    parameter int          ADD_LAT  = 2,
    parameter int          MAX_ITER = 8,
    parameter logic [31:0] PI_2     = 32'h3FC90FDB,
    parameter logic [31:0] PI       = 32'h40490FDB
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    input  logic [31:0] theta_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] x_out,
    output logic [31:0] y_out,
    output logic [31:0] theta_out,
    output logic        out_err
);
    localparam int IW = $clog2(MAX_ITER + 1);
    localparam int WW = $clog2(ADD_LAT + 1);

    typedef enum logic [1:0] {IDLE, CHECK, ADD_WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [31:0]     x_q, x_d, y_q, y_d, th_q, th_d;
    logic            err_q, err_d;
    logic [IW-1:0]   iter_q, iter_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [31:0]     add_b, add_res;

    // Step toward zero: subtract pi from a positive angle, add pi to a negative one.
    assign add_b = {~th_q[31], PI[30:0]};

    ahfp_add_sub #(.LAT(ADD_LAT)) u_add (
        .clk      (clk),
        .rst_n    (rst_n),
        .dataa_i  (th_q),
        .datab_i  (add_b),
        .result_o (add_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= 32'd0;
            y_q     <= 32'd0;
            th_q    <= 32'd0;
            err_q   <= 1'b0;
            iter_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            th_q    <= th_d;
            err_q   <= err_d;
            iter_q  <= iter_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        th_d      = th_q;
        err_d     = err_q;
        iter_d    = iter_q;
        wait_d    = wait_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    x_d     = x_in;
                    y_d     = y_in;
                    th_d    = theta_in;
                    err_d   = 1'b0;
                    iter_d  = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (th_q[30:23] == 8'hFF) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (th_q[30:0] <= PI_2[30:0]) begin
                    state_d = DONE;
                end else if (iter_q == IW'(MAX_ITER)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    // Rotation by pi is an exact sign flip of x and y.
                    x_d[31] = ~x_q[31];
                    y_d[31] = ~y_q[31];
                    iter_d  = iter_q + IW'(1);
                    wait_d  = WW'(ADD_LAT);
                    state_d = ADD_WAIT;
                end
            end
            ADD_WAIT: begin
                if (wait_q <= WW'(1)) begin
                    wait_d  = '0;
                    th_d    = add_res;
                    state_d = CHECK;
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign x_out     = x_q;
    assign y_out     = y_q;
    assign theta_out = th_q;
    assign out_err   = (state_q == DONE) && err_q;
endmodule

// File: tb/tb_ahfp_cordic_range_reduce.sv
// Directed bench for ahfp_cordic_range_reduce: hand-computed float32 vectors, latency, error, backpressure and reset.
module tb_ahfp_cordic_range_reduce;
    localparam int ADD_LAT  = 2;
    localparam int MAX_ITER = 8;
    localparam int STEP     = ADD_LAT + 1;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [31:0] x_in, y_in, theta_in, x_out, y_out, theta_out;
    int          errors = 0;
    int          checks = 0;
    int          cyc;

    always #5 clk = ~clk;

    ahfp_cordic_range_reduce #(.ADD_LAT(ADD_LAT), .MAX_ITER(MAX_ITER)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .theta_in  (theta_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .theta_out (theta_out),
        .out_err   (out_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ulp(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int tol);
        int diff;
        checks++;
        diff = int'({1'b0, obs[30:0]}) - int'({1'b0, exp[30:0]});
        assert (obs[31] === exp[31] && diff <= tol && diff >= -tol) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (+-%0d ulp)", tag, obs, exp, tol);
        end
    endtask

    // Present one triple, count cycles from the handshake cycle until out_valid.
    task automatic send(input string tag, input logic [31:0] x, input logic [31:0] y, input logic [31:0] th);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        x_in = x;
        y_in = y;
        theta_in = th;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic vec(input string tag, input logic [31:0] x, input logic [31:0] y, input logic [31:0] th,
                       input int exp_lat, input logic [31:0] ex, input logic [31:0] ey,
                       input logic [31:0] eth, input int tol, input logic eerr);
        send(tag, x, y, th);
        chk({tag, "_lat"}, cyc, exp_lat);
        chk({tag, "_x"}, x_out, ex);
        chk({tag, "_y"}, y_out, ey);
        if (!eerr) chk_ulp({tag, "_theta"}, theta_out, eth, tol);
        chk({tag, "_err"}, {31'd0, out_err}, {31'd0, eerr});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_vld_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x_in = 32'd0;
        y_in = 32'd0;
        theta_in = 32'd0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_x", x_out, 32'd0);
        chk("rst_theta", theta_out, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // In-range, one step, two steps, negative angle.
        vec("in1",   32'h3F800000, 32'h00000000, 32'h3F800000, 2, 32'h3F800000, 32'h00000000, 32'h3F800000, 0, 1'b0);
        vec("two",   32'h3F800000, 32'h00000000, 32'h40000000, 2 + STEP, 32'hBF800000, 32'h80000000, 32'hBF921FB6, 1, 1'b0);
        vec("seven", 32'h3F000000, 32'h40400000, 32'h40E00000, 2 + 2 * STEP, 32'h3F000000, 32'h40400000, 32'h3F378128, 2, 1'b0);
        vec("neg2",  32'h40400000, 32'hBF000000, 32'hC0000000, 2 + STEP, 32'hC0400000, 32'h3F000000, 32'h3F921FB6, 1, 1'b0);

        // Error cases: NaN, -Inf, iteration budget exhausted (even step count leaves x/y signs intact).
        vec("nan",   32'h3F800000, 32'h3F800000, 32'h7FC00000, 2, 32'h3F800000, 32'h3F800000, 32'h0, 0, 1'b1);
        vec("ninf",  32'h3F800000, 32'h40000000, 32'hFF800000, 2, 32'h3F800000, 32'h40000000, 32'h0, 0, 1'b1);
        vec("huge",  32'h3F800000, 32'hC0000000, 32'h4B000000, 2 + MAX_ITER * STEP, 32'h3F800000, 32'hC0000000, 32'h0, 0, 1'b1);

        // Boundary, zeros and denormal.
        vec("pi2p",  32'h3F800000, 32'h3F000000, 32'h3FC90FDB, 2, 32'h3F800000, 32'h3F000000, 32'h3FC90FDB, 0, 1'b0);
        vec("pi2n",  32'h3F800000, 32'h3F000000, 32'hBFC90FDB, 2, 32'h3F800000, 32'h3F000000, 32'hBFC90FDB, 0, 1'b0);
        vec("pi2up", 32'h3F800000, 32'h3F000000, 32'h3FC90FDC, 2 + STEP, 32'hBF800000, 32'hBF000000, 32'hBFC90FDA, 0, 1'b0);
        vec("nzero", 32'h12345678, 32'h80000000, 32'h80000000, 2, 32'h12345678, 32'h80000000, 32'h80000000, 0, 1'b0);
        vec("denrm", 32'h3F800000, 32'h00000000, 32'h00000001, 2, 32'h3F800000, 32'h00000000, 32'h00000001, 0, 1'b0);

        // Backpressure: result held, new input ignored while out_ready is low.
        send("bp", 32'h40A00000, 32'h3E800000, 32'h3F000000);
        chk("bp_lat", cyc, 2);
        x_in = 32'h11111111;
        y_in = 32'h22222222;
        theta_in = 32'h3E000000;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_vld", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
        end
        chk("bp_x", x_out, 32'h40A00000);
        chk("bp_y", y_out, 32'h3E800000);
        chk("bp_theta", theta_out, 32'h3F000000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_vld", {31'd0, out_valid}, 32'd0);
        chk("bp_release_rdy", {31'd0, in_ready}, 32'd1);

        // Asynchronous reset while the adder is busy.
        x_in = 32'h3F800000;
        y_in = 32'h00000000;
        theta_in = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", {31'd0, out_valid}, 32'd0);
        chk("arst_rdy", {31'd0, in_ready}, 32'd1);
        chk("arst_theta", theta_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vec("post1", 32'h40000000, 32'h3F800000, 32'hBF000000, 2, 32'h40000000, 32'h3F800000, 32'hBF000000, 0, 1'b0);
        vec("post2", 32'h40000000, 32'h3F800000, 32'h40000000, 2 + STEP, 32'hC0000000, 32'hBF800000, 32'hBF921FB6, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
